// File: rtl/qos_pkg.sv
// Shared constants and types for the QoS virtual-channel pop arbiter.
package qos_pkg;

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned VC_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int unsigned DEF_W0 = 4;
  localparam int unsigned DEF_W1 = 3;
  localparam int unsigned DEF_W2 = 2;
  localparam int unsigned DEF_W3 = 1;

  // Modulo-NUM_VC step from a VC index.
  function automatic logic [VC_W-1:0] vc_add(input logic [VC_W-1:0] base, input int off);
    return base + VC_W'(off);
  endfunction

endpackage

// File: rtl/rr_next_select.sv
// Rotating-priority picker: first requester after last_i, wrapping back to last_i itself.
module rr_next_select
  import qos_pkg::*;
(
  input  logic [NUM_VC-1:0] req_i,
  input  logic [VC_W-1:0]   last_i,
  output logic [VC_W-1:0]   sel_o,
  output logic              valid_o
);

  logic [VC_W-1:0] cand;

  always_comb begin
    sel_o   = last_i;
    valid_o = 1'b0;
    cand    = last_i;
    // Walk from furthest to nearest so the nearest requester overwrites the rest.
    for (int k = NUM_VC; k >= 1; k--) begin
      cand = vc_add(last_i, k);
      if (req_i[cand]) begin
        sel_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_pop_arbiter.sv
// Weighted round-robin pop arbiter: drains four VC FIFOs into one downstream FIFO,
// one pop per cycle, with a one-cycle bubble on every grant change.
module qos_wrr_pop_arbiter
  import qos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned CW         = 4,
  parameter int unsigned W0         = DEF_W0,
  parameter int unsigned W1         = DEF_W1,
  parameter int unsigned W2         = DEF_W2,
  parameter int unsigned W3         = DEF_W3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VC-1:0]     empty_i,
  input  logic                  almost_full_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic [DATA_WIDTH-1:0] data3_i,
  output logic [NUM_VC-1:0]     pop_o,
  output logic                  push_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [VC_W-1:0]       active_o,
  output logic                  serving_o
);

  state_e          state_q, state_d;
  logic [VC_W-1:0] cur_q, cur_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            push_q, push_d;
  logic [VC_W-1:0] sel_q, sel_d;

  logic [VC_W-1:0]       pick_sel;
  logic                  pick_valid;
  logic [CW-1:0]         pick_weight;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] data_sel;

  rr_next_select u_rr_next_select (
    .req_i   (~empty_i),
    .last_i  (cur_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_weight = CW'(W0);
    unique case (pick_sel)
      2'd0: pick_weight = CW'(W0);
      2'd1: pick_weight = CW'(W1);
      2'd2: pick_weight = CW'(W2);
      2'd3: pick_weight = CW'(W3);
      default: pick_weight = CW'(W0);
    endcase
  end

  // almost_full_i gates the pop in the same cycle; the downstream slack absorbs the one in flight.
  assign pop_ok = (state_q == SERVE) && !empty_i[cur_q] && !almost_full_i &&
                  (credit_q != '0);

  always_comb begin
    pop_o        = '0;
    pop_o[cur_q] = pop_ok;
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cur_d    = pick_sel;
          credit_d = pick_weight;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (pop_ok) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CW'(1)) begin
            state_d = IDLE;
          end
        end else if (empty_i[cur_q] || (credit_q == '0)) begin
          // Leftover credit is forfeited once the VC runs dry.
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_d = pop_ok;
  assign sel_d  = cur_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= VC_W'(NUM_VC - 1);
      credit_q <= '0;
      push_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      push_q   <= push_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    data_sel = '0;
    unique case (sel_q)
      2'd0: data_sel = data0_i;
      2'd1: data_sel = data1_i;
      2'd2: data_sel = data2_i;
      2'd3: data_sel = data3_i;
      default: data_sel = '0;
    endcase
  end

  assign push_o    = push_q;
  assign data_o    = push_q ? data_sel : '0;
  assign active_o  = cur_q;
  assign serving_o = (state_q == SERVE);

endmodule
